// File: rtl/immediate_encode.sv
// immediate_encode: packs an immediate plus register/function fields into a
// 32-bit RV32IM instruction word. This is the inverse of the decode-stage
// immediate generator. It also expands the load-immediate (LI) pseudo-op into
// an LUI/ADDI pair, or into a single word when one half is zero.
// Optional feature: define IMM_ENC_RANGE_CHECK_EN to compute o_err. When it is
// undefined, o_err is tied 0 and out-of-range immediates are silently truncated.
// Ports:
//   i_clk, i_reset       clock (rising edge), asynchronous active-high reset
//   i_in_valid/o_in_ready request handshake
//   i_imm_sel            000 U, 001 J, 010 S, 011 B, 100 I-signed,
//                        101 shift, 110 I-unsigned, 111 LI
//   i_imm                immediate value
//   i_opcode, i_rd, i_funct3, i_rs1, i_rs2, i_funct7  instruction fields
//   o_out_valid/i_out_ready output handshake
//   o_out                encoded word
//   o_out_last           final word of the current request
//   o_err                immediate not representable in the selected format
module immediate_encode (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [2:0]  i_imm_sel,
  input  logic [31:0] i_imm,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [2:0]  i_funct3,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [6:0]  i_funct7,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_out,
  output logic        o_out_last,
  output logic        o_err
);
  localparam logic [2:0] SEL_U  = 3'b000;
  localparam logic [2:0] SEL_J  = 3'b001;
  localparam logic [2:0] SEL_S  = 3'b010;
  localparam logic [2:0] SEL_B  = 3'b011;
  localparam logic [2:0] SEL_I  = 3'b100;
  localparam logic [2:0] SEL_SH = 3'b101;
  localparam logic [2:0] SEL_IU = 3'b110;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  typedef enum logic [1:0] {IDLE, HOLD, HOLD_LUI} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_out, w_out_nxt;
  logic [31:0] r_addi, w_addi_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_last, w_last_nxt;
  logic        r_err, w_err_nxt;

  logic [31:0] w_word;
  logic [31:0] w_addi_word;
  logic        w_two;
  logic        w_err;
  logic        w_accept;
  logic [19:0] w_li_hi;
  logic [11:0] w_li_lo;

  // Format packing of the incoming request (first word only for a two-word LI)
  always_comb begin : pack
    // Round hi up when lo is negative so that ADDI's sign extension cancels out
    w_li_hi     = i_imm[31:12] + 20'(i_imm[11]);
    w_li_lo     = i_imm[11:0];
    w_two       = 1'b0;
    w_addi_word = {w_li_lo, i_rd, 3'b000, i_rd, OP_ADDI};
    w_word      = '0;
    case (i_imm_sel)
      SEL_U:  w_word = {i_imm[31:12], i_rd, i_opcode};
      SEL_J:  w_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
      SEL_S:  w_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
      SEL_B:  w_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                        i_imm[4:1], i_imm[11], i_opcode};
      SEL_I,
      SEL_IU: w_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
      SEL_SH: w_word = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode};
      default: begin
        if (w_li_hi == 20'd0) begin
          w_word = {w_li_lo, 5'd0, 3'b000, i_rd, OP_ADDI};
        end else begin
          w_word = {w_li_hi, i_rd, OP_LUI};
          w_two  = (w_li_lo != 12'd0);
        end
      end
    endcase
  end

`ifdef IMM_ENC_RANGE_CHECK_EN
  // Representability of the immediate in the selected format
  always_comb begin : range_check
    w_err = 1'b0;
    case (i_imm_sel)
      SEL_U:  w_err = (i_imm[11:0] != 12'd0);
      SEL_J:  w_err = i_imm[0] || (i_imm[31:20] != {12{i_imm[20]}});
      SEL_B:  w_err = i_imm[0] || (i_imm[31:12] != {20{i_imm[12]}});
      SEL_S,
      SEL_I:  w_err = (i_imm[31:11] != {21{i_imm[11]}});
      SEL_SH: w_err = (i_imm[31:5] != 27'd0);
      SEL_IU: w_err = (i_imm[31:12] != 20'd0);
      default: w_err = 1'b0;
    endcase
  end
`else
  assign w_err = 1'b0;
`endif

  assign o_in_ready = ((r_state == IDLE) || ((r_state == HOLD) && i_out_ready)) && !i_reset;
  assign w_accept   = i_in_valid && o_in_ready;

  // Next-state and output-register logic
  always_comb begin : next_state
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_addi_nxt  = r_addi;
    w_last_nxt  = r_last;
    w_err_nxt   = r_err;
    case (r_state)
      HOLD_LUI: begin
        if (i_out_ready) begin
          w_state_nxt = HOLD;
          w_out_nxt   = r_addi;
          w_last_nxt  = 1'b1;
          w_err_nxt   = 1'b0;
        end
      end
      default: begin
        // A new accept in HOLD replaces OUT on the same edge as the handshake
        if (w_accept) begin
          w_state_nxt = w_two ? HOLD_LUI : HOLD;
          w_out_nxt   = w_word;
          w_addi_nxt  = w_addi_word;
          w_last_nxt  = !w_two;
          w_err_nxt   = w_err;
        end else if ((r_state == HOLD) && i_out_ready) begin
          w_state_nxt = IDLE;
        end
      end
    endcase
    w_valid_nxt = (w_state_nxt != IDLE);
  end

  // State and output registers; reset drops any pending ADDI
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_out   <= '0;
      r_addi  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_addi  <= w_addi_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign o_out_valid = r_valid;
  assign o_out       = r_out;
  assign o_out_last  = r_last;
  assign o_err       = r_err;

endmodule
